// File: rtl/sync_fifo_wl_pkg.sv
// Shared constants, read-mode encoding and parameter legality helpers
// for the water-level staging FIFO.
package sync_fifo_wl_pkg;

    localparam int DW_MIN = 1;
    localparam int DW_MAX = 256;
    localparam int AW_MIN = 4;
    localparam int AW_MAX = 10;

    typedef enum logic [1:0] {
        RD_STD     = 2'd0,
        RD_STD_REG = 2'd1,
        RD_FWFT    = 2'd2
    } rd_mode_e;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // OUT_REG only matters in standard mode; FWFT overrides it.
    function automatic rd_mode_e rd_mode(input bit fwft, input bit out_reg);
        return fwft ? RD_FWFT : (out_reg ? RD_STD_REG : RD_STD);
    endfunction

    function automatic bit width_ok(input int dw, input int aw);
        return (dw >= DW_MIN) && (dw <= DW_MAX)
            && (aw >= AW_MIN) && (aw <= AW_MAX);
    endfunction

    function automatic bit thresh_ok(input int aw, input int afn,
                                     input int aen);
        return (afn >= 1) && (afn <= fifo_depth(aw))
            && (aen >= 0) && (aen <= fifo_depth(aw) - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_wl_if.sv
// Write/read handshake bundle of the water-level FIFO; the master
// side produces and consumes words, the slave side is the FIFO.
interface sync_fifo_wl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);

    logic                  clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   water_level;

    modport master (
        output clr,
        output wr_en,
        output wr_data,
        output rd_en,
        input  full,
        input  almost_full,
        input  overflow,
        input  rd_data,
        input  rd_valid,
        input  empty,
        input  almost_empty,
        input  underflow,
        input  water_level
    );

    modport slave (
        input  clr,
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output full,
        output almost_full,
        output overflow,
        output rd_data,
        output rd_valid,
        output empty,
        output almost_empty,
        output underflow,
        output water_level
    );

endinterface

// File: rtl/sync_fifo_wl_dpram.sv
// Distributed dual-port storage: synchronous write, asynchronous
// read, contents deliberately left unreset.
module sync_fifo_wl_dpram
    import sync_fifo_wl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with live water level, flush, overflow/underflow
// pulses and selectable standard / registered / FWFT read port.
module sync_fifo_wl
    import sync_fifo_wl_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 10,
    parameter int FWFT             = 0,
    parameter int OUT_REG          = 0,
    parameter int ALMOST_FULL_NUM  = 11,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sync_fifo_wl_if.slave bus
);

    localparam int       PW    = ADDR_WIDTH + 1;
    localparam int       DEPTH = fifo_depth(ADDR_WIDTH);
    localparam rd_mode_e MODE  = rd_mode(FWFT != 0, OUT_REG != 0);

    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
    localparam logic [PW-1:0] AF_L    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_L    = PW'(ALMOST_EMPTY_NUM);

    if (!width_ok(DATA_WIDTH, ADDR_WIDTH)) begin : g_bad_width
        $error("sync_fifo_wl: DATA_WIDTH/ADDR_WIDTH out of range");
    end

    if (!thresh_ok(ADDR_WIDTH, ALMOST_FULL_NUM,
                   ALMOST_EMPTY_NUM)) begin : g_bad_thresh
        $error("sync_fifo_wl: ALMOST_* threshold out of range");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                  s1_vld_q, s1_vld_d;
    logic                  s2_vld_q, s2_vld_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full   = (level_q == DEPTH_L);
    assign empty  = (level_q == '0);
    assign wr_acc = bus.wr_en && !full && !bus.clr;
    assign rd_acc = bus.rd_en && !empty && !bus.clr;

    sync_fifo_wl_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = bus.wr_en && full && !bus.clr;
        udf_d    = bus.rd_en && empty && !bus.clr;
        if (bus.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + PW'(1);
                2'b01:   level_d = level_q - PW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Stage 2 only feeds the port in registered mode; a flush drops
    // whatever word is still travelling through stage 1.
    always_comb begin
        s1_vld_d  = rd_acc;
        s1_data_d = rd_acc ? ram_rdata : s1_data_q;
        s2_vld_d  = s1_vld_q && !bus.clr;
        s2_data_d = s2_vld_d ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
        end
    end

    always_comb begin
        bus.rd_data  = s1_data_q;
        bus.rd_valid = s1_vld_q;
        case (MODE)
            RD_FWFT: begin
                bus.rd_data  = empty ? '0 : ram_rdata;
                bus.rd_valid = !empty;
            end
            RD_STD_REG: begin
                bus.rd_data  = s2_data_q;
                bus.rd_valid = s2_vld_q;
            end
            default: begin
                bus.rd_data  = s1_data_q;
                bus.rd_valid = s1_vld_q;
            end
        endcase
    end

    assign bus.full         = full;
    assign bus.almost_full  = (level_q >= AF_L);
    assign bus.empty        = empty;
    assign bus.almost_empty = (level_q <= AE_L);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign bus.water_level  = level_q;

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Directed bench for sync_fifo_wl: standard, FWFT and registered
// read ports side by side on one clock and reset.
module tb_sync_fifo_wl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vecs  = 0;
    int   errs  = 0;

    sync_fifo_wl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_std ();
    sync_fifo_wl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_fw ();
    sync_fifo_wl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_or ();

    sync_fifo_wl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .OUT_REG(0),
        .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) u_std (.clk(clk), .rst_n(rst_n), .bus(if_std));

    sync_fifo_wl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .OUT_REG(0),
        .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) u_fw (.clk(clk), .rst_n(rst_n), .bus(if_fw));

    sync_fifo_wl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .OUT_REG(1),
        .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) u_or (.clk(clk), .rst_n(rst_n), .bus(if_or));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_std.clr = 0; if_std.wr_en = 0; if_std.rd_en = 0;
        if_std.wr_data = 8'h00;
        if_fw.clr = 0; if_fw.wr_en = 0; if_fw.rd_en = 0;
        if_fw.wr_data = 8'h00;
        if_or.clr = 0; if_or.wr_en = 0; if_or.rd_en = 0;
        if_or.wr_data = 8'h00;
    endtask

    task automatic test_reset();
        logic [6:0] f;
        rst_n = 1'b0;
        idle_all();
        repeat (3) tick();
        f = {if_std.empty, if_std.almost_empty, if_std.full,
             if_std.almost_full, if_std.overflow, if_std.underflow,
             if_std.rd_valid};
        vecs++;
        if (f !== 7'b1100000) begin
            errs++;
            $display("FAIL reset_flags got %b want 1100000", f);
        end
        vecs++;
        if (if_std.water_level !== 5'd0 || if_std.rd_data !== 8'h00) begin
            errs++;
            $display("FAIL reset_level lvl=%0d data=%h want 0/00",
                     if_std.water_level, if_std.rd_data);
        end
        vecs++;
        if (if_fw.rd_valid !== 1'b0 || if_fw.rd_data !== 8'h00 ||
            if_or.rd_valid !== 1'b0 || if_or.rd_data !== 8'h00) begin
            errs++;
            $display("FAIL reset_ports fw=%b/%h or=%b/%h want 0/00",
                     if_fw.rd_valid, if_fw.rd_data,
                     if_or.rd_valid, if_or.rd_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        int n;
        logic [4:0] e_lvl;
        logic e_af, e_full, e_ovf, e_ae;
        for (int i = 0; i < 17; i++) begin
            if_std.wr_en   = 1'b1;
            if_std.wr_data = 8'(i);
            tick();
            n      = (i < 16) ? i + 1 : 16;
            e_lvl  = 5'(n);
            e_af   = (n >= 14);
            e_full = (n == 16);
            e_ovf  = (i == 16);
            e_ae   = (n <= 2);
            vecs++;
            if (if_std.water_level !== e_lvl ||
                if_std.almost_full !== e_af || if_std.full !== e_full ||
                if_std.overflow !== e_ovf ||
                if_std.almost_empty !== e_ae || if_std.empty !== 1'b0) begin
                errs++;
                $display("FAIL fill[%0d] lvl=%0d af=%b f=%b ov=%b ae=%b e=%b want lvl=%0d af=%b f=%b ov=%b ae=%b e=0",
                         i, if_std.water_level, if_std.almost_full,
                         if_std.full, if_std.overflow,
                         if_std.almost_empty, if_std.empty,
                         e_lvl, e_af, e_full, e_ovf, e_ae);
            end
        end
        if_std.wr_en = 1'b0;
        tick();
        vecs++;
        if (if_std.overflow !== 1'b0 || if_std.water_level !== 5'd16 ||
            if_std.rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL fill_hold ov=%b lvl=%0d rv=%b want 0/16/0",
                     if_std.overflow, if_std.water_level, if_std.rd_valid);
        end
    endtask

    task automatic test_readback();
        logic [4:0] e_lvl;
        if_std.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            e_lvl = 5'(15 - i);
            vecs++;
            if (if_std.rd_valid !== 1'b1 || if_std.rd_data !== 8'(i) ||
                if_std.water_level !== e_lvl ||
                if_std.empty !== (i == 15) ||
                if_std.almost_empty !== (e_lvl <= 5'd2) ||
                if_std.full !== 1'b0) begin
                errs++;
                $display("FAIL read[%0d] rv=%b d=%h lvl=%0d e=%b ae=%b f=%b want d=%h lvl=%0d",
                         i, if_std.rd_valid, if_std.rd_data,
                         if_std.water_level, if_std.empty,
                         if_std.almost_empty, if_std.full, 8'(i), e_lvl);
            end
        end
        if_std.rd_en = 1'b0;
        tick();
        vecs++;
        if (if_std.rd_valid !== 1'b0 || if_std.rd_data !== 8'h0F ||
            if_std.underflow !== 1'b0) begin
            errs++;
            $display("FAIL read_idle rv=%b d=%h un=%b want 0/0f/0",
                     if_std.rd_valid, if_std.rd_data, if_std.underflow);
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 16; i++) begin
            if_std.wr_en   = 1'b1;
            if_std.wr_data = 8'(8'h10 + i);
            tick();
        end
        if_std.wr_en   = 1'b1;
        if_std.rd_en   = 1'b1;
        if_std.wr_data = 8'hAA;
        tick();
        if_std.wr_en = 1'b0;
        vecs++;
        if (if_std.water_level !== 5'd15 || if_std.overflow !== 1'b1 ||
            if_std.rd_valid !== 1'b1 || if_std.rd_data !== 8'h10) begin
            errs++;
            $display("FAIL full_rw lvl=%0d ov=%b rv=%b d=%h want 15/1/1/10",
                     if_std.water_level, if_std.overflow,
                     if_std.rd_valid, if_std.rd_data);
        end
        for (int i = 1; i < 16; i++) begin
            tick();
            vecs++;
            if (if_std.rd_data !== 8'(8'h10 + i) || if_std.overflow !== 1'b0) begin
                errs++;
                $display("FAIL drain[%0d] d=%h ov=%b want %h/0",
                         i, if_std.rd_data, if_std.overflow, 8'(8'h10 + i));
            end
        end
        vecs++;
        if (if_std.empty !== 1'b1) begin
            errs++;
            $display("FAIL drain_empty got %b want 1", if_std.empty);
        end
        if_std.wr_en   = 1'b1;
        if_std.wr_data = 8'h55;
        tick();
        if_std.wr_en = 1'b0;
        if_std.rd_en = 1'b0;
        vecs++;
        if (if_std.water_level !== 5'd1 || if_std.underflow !== 1'b1 ||
            if_std.rd_valid !== 1'b0 || if_std.empty !== 1'b0) begin
            errs++;
            $display("FAIL empty_rw lvl=%0d un=%b rv=%b e=%b want 1/1/0/0",
                     if_std.water_level, if_std.underflow,
                     if_std.rd_valid, if_std.empty);
        end
        if_std.rd_en = 1'b1;
        tick();
        if_std.rd_en = 1'b0;
        vecs++;
        if (if_std.rd_data !== 8'h55 || if_std.rd_valid !== 1'b1 ||
            if_std.empty !== 1'b1 || if_std.underflow !== 1'b0) begin
            errs++;
            $display("FAIL empty_rw_read d=%h rv=%b e=%b un=%b want 55/1/1/0",
                     if_std.rd_data, if_std.rd_valid,
                     if_std.empty, if_std.underflow);
        end
    endtask

    task automatic test_fwft();
        if_fw.wr_en   = 1'b1;
        if_fw.wr_data = 8'h3C;
        tick();
        if_fw.wr_en = 1'b0;
        vecs++;
        if (if_fw.rd_valid !== 1'b1 || if_fw.rd_data !== 8'h3C ||
            if_fw.empty !== 1'b0) begin
            errs++;
            $display("FAIL fwft_head rv=%b d=%h e=%b want 1/3c/0",
                     if_fw.rd_valid, if_fw.rd_data, if_fw.empty);
        end
        if_fw.rd_en = 1'b1;
        tick();
        if_fw.rd_en = 1'b0;
        vecs++;
        if (if_fw.empty !== 1'b1 || if_fw.rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL fwft_pop e=%b rv=%b want 1/0",
                     if_fw.empty, if_fw.rd_valid);
        end
        if_fw.wr_en   = 1'b1;
        if_fw.wr_data = 8'h11;
        tick();
        if_fw.wr_data = 8'h22;
        tick();
        if_fw.wr_en = 1'b0;
        vecs++;
        if (if_fw.rd_data !== 8'h11 || if_fw.water_level !== 5'd2) begin
            errs++;
            $display("FAIL fwft_two d=%h lvl=%0d want 11/2",
                     if_fw.rd_data, if_fw.water_level);
        end
        if_fw.rd_en = 1'b1;
        tick();
        if_fw.rd_en = 1'b0;
        vecs++;
        if (if_fw.rd_data !== 8'h22 || if_fw.rd_valid !== 1'b1) begin
            errs++;
            $display("FAIL fwft_next d=%h rv=%b want 22/1",
                     if_fw.rd_data, if_fw.rd_valid);
        end
    endtask

    task automatic test_out_reg();
        if_or.wr_en   = 1'b1;
        if_or.wr_data = 8'h7E;
        tick();
        if_or.wr_en = 1'b0;
        if_or.rd_en = 1'b1;
        tick();
        if_or.rd_en = 1'b0;
        vecs++;
        if (if_or.rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL oreg_n rv=%b want 0", if_or.rd_valid);
        end
        tick();
        vecs++;
        if (if_or.rd_valid !== 1'b1 || if_or.rd_data !== 8'h7E) begin
            errs++;
            $display("FAIL oreg_n1 rv=%b d=%h want 1/7e",
                     if_or.rd_valid, if_or.rd_data);
        end
        tick();
        vecs++;
        if (if_or.rd_valid !== 1'b0 || if_or.rd_data !== 8'h7E) begin
            errs++;
            $display("FAIL oreg_hold rv=%b d=%h want 0/7e",
                     if_or.rd_valid, if_or.rd_data);
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 9; i++) begin
            if_std.wr_en   = 1'b1;
            if_std.wr_data = 8'(8'h30 + i);
            tick();
        end
        if_std.wr_en = 1'b0;
        vecs++;
        if (if_std.water_level !== 5'd9) begin
            errs++;
            $display("FAIL clr_pre lvl=%0d want 9", if_std.water_level);
        end
        if_std.clr     = 1'b1;
        if_std.wr_en   = 1'b1;
        if_std.rd_en   = 1'b1;
        if_std.wr_data = 8'hEE;
        tick();
        if_std.clr   = 1'b0;
        if_std.wr_en = 1'b0;
        if_std.rd_en = 1'b0;
        vecs++;
        if (if_std.water_level !== 5'd0 || if_std.empty !== 1'b1 ||
            if_std.almost_empty !== 1'b1 || if_std.overflow !== 1'b0 ||
            if_std.underflow !== 1'b0 || if_std.rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL clr lvl=%0d e=%b ae=%b ov=%b un=%b rv=%b want 0/1/1/0/0/0",
                     if_std.water_level, if_std.empty, if_std.almost_empty,
                     if_std.overflow, if_std.underflow, if_std.rd_valid);
        end
        if_std.wr_en   = 1'b1;
        if_std.wr_data = 8'h99;
        tick();
        if_std.wr_en = 1'b0;
        if_std.rd_en = 1'b1;
        tick();
        if_std.rd_en = 1'b0;
        vecs++;
        if (if_std.rd_data !== 8'h99 || if_std.empty !== 1'b1) begin
            errs++;
            $display("FAIL clr_after d=%h e=%b want 99/1",
                     if_std.rd_data, if_std.empty);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] f;
        for (int i = 0; i < 4; i++) begin
            if_std.wr_en   = 1'b1;
            if_std.wr_data = 8'(8'h60 + i);
            tick();
        end
        if_or.wr_en   = 1'b1;
        if_or.wr_data = 8'h12;
        tick();
        if_or.wr_en = 1'b0;
        if_or.rd_en = 1'b1;
        tick();
        if_or.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        f = {if_std.empty, if_std.almost_empty, if_std.full,
             if_std.almost_full, if_std.overflow, if_std.underflow,
             if_std.rd_valid};
        vecs++;
        if (f !== 7'b1100000 || if_std.water_level !== 5'd0 ||
            if_std.rd_data !== 8'h00) begin
            errs++;
            $display("FAIL rst_mid flags=%b lvl=%0d d=%h want 1100000/0/00",
                     f, if_std.water_level, if_std.rd_data);
        end
        idle_all();
        tick();
        vecs++;
        if (if_or.rd_valid !== 1'b0 || if_or.rd_data !== 8'h00) begin
            errs++;
            $display("FAIL rst_inflight rv=%b d=%h want 0/00",
                     if_or.rd_valid, if_or.rd_data);
        end
        rst_n = 1'b1;
        tick();
        vecs++;
        if (if_std.empty !== 1'b1 || if_std.water_level !== 5'd0 ||
            if_or.rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_release e=%b lvl=%0d orv=%b want 1/0/0",
                     if_std.empty, if_std.water_level, if_or.rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_readback();
        test_boundary();
        test_fwft();
        test_out_reg();
        test_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
